// File: rtl/scan_frame_pack_if.sv
// Stream-side bundle for scan_frame_pack: scan buffer read port, link transmit port, status.
// master = the packetizer, slave = its environment (buffer, transmitter, host status reader).
interface scan_frame_pack_if;
   logic        i_send_sync;
   logic [31:0] i_st_data;
   logic        i_st_vld;
   logic        o_st_rdy;
   logic [31:0] o_tx_data;
   logic        o_tx_vld;
   logic        i_tx_rdy;
   logic        o_tx_sop;
   logic        o_tx_eop;
   logic        o_busy;
   logic [15:0] o_frame_cnt;
   logic [7:0]  o_drop_cnt;

   modport master (
      input  i_send_sync, i_st_data, i_st_vld, i_tx_rdy,
      output o_st_rdy, o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop,
             o_busy, o_frame_cnt, o_drop_cnt
   );

   modport slave (
      output i_send_sync, i_st_data, i_st_vld, i_tx_rdy,
      input  o_st_rdy, o_tx_data, o_tx_vld, o_tx_sop, o_tx_eop,
             o_busy, o_frame_cnt, o_drop_cnt
   );
endinterface

// File: rtl/scan_frame_pack.sv
// Wraps one scan of SCAN_WORDS payload words into a framed link transfer (2 headers + payload).
// Define SCAN_FRAME_CHKSUM_EN to build the checksum trailer word (carries EOP instead of payload).
//
// state   | meaning
// IDLE    | waiting for i_send_sync, outputs quiet
// HDR0    | presenting {SYNC_WORD, frame count}, SOP
// HDR1    | presenting {8'h01, 8'h00, SCAN_WORDS}
// PAYLOAD | scan words passed straight through
// TRAIL   | presenting payload sum, EOP (checksum build only)
module scan_frame_pack #(
   parameter int unsigned SCAN_WORDS = 4096,
   parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
   input  logic               clk,
   input  logic               rst,
   scan_frame_pack_if.master  bus
);

   localparam logic [15:0] LAST_IDX = 16'(SCAN_WORDS - 1);
   localparam logic [15:0] LEN_WORD = 16'(SCAN_WORDS);

`ifdef SCAN_FRAME_CHKSUM_EN
   typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, TRAIL} state_t;
`else
   typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAYLOAD} state_t;
`endif

   state_t      state_q;
   logic [31:0] word_q;
   logic [15:0] cnt_q;
   logic [15:0] frame_q, frame_d;
   logic [7:0]  drop_q, drop_d;
   logic        vld_q, sop_q, busy_q;
   logic        in_pay, pay_hs, last_pay, eop_hs;
`ifdef SCAN_FRAME_CHKSUM_EN
   logic [31:0] chk_q;
   logic        eop_q;
`endif

   assign in_pay   = (state_q == PAYLOAD);
   assign pay_hs   = in_pay & bus.i_st_vld & bus.i_tx_rdy;
   assign last_pay = in_pay & (cnt_q == LAST_IDX);

`ifdef SCAN_FRAME_CHKSUM_EN
   assign eop_hs        = eop_q & bus.i_tx_rdy;
   assign bus.o_tx_eop  = eop_q;
`else
   assign eop_hs        = last_pay & pay_hs;
   assign bus.o_tx_eop  = last_pay & bus.i_st_vld;
`endif

   // Payload is a zero-latency passthrough; everything else comes from word_q/vld_q.
   assign bus.o_st_rdy    = in_pay & bus.i_tx_rdy;
   assign bus.o_tx_data   = in_pay ? bus.i_st_data : word_q;
   assign bus.o_tx_vld    = in_pay ? bus.i_st_vld  : vld_q;
   assign bus.o_tx_sop    = sop_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_frame_cnt = frame_q;
   assign bus.o_drop_cnt  = drop_q;

   always_comb begin
      frame_d = frame_q + {15'd0, eop_hs};
      drop_d  = drop_q;
      if (bus.i_send_sync && (state_q != IDLE) && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
         frame_q <= '0;
         drop_q  <= '0;
         vld_q   <= 1'b0;
         sop_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef SCAN_FRAME_CHKSUM_EN
         chk_q   <= '0;
         eop_q   <= 1'b0;
`endif
      end else begin
         frame_q <= frame_d;
         drop_q  <= drop_d;
         case (state_q)
            IDLE: begin
               if (bus.i_send_sync) begin
                  state_q <= HDR0;
                  word_q  <= {SYNC_WORD, frame_q};
                  vld_q   <= 1'b1;
                  sop_q   <= 1'b1;
                  busy_q  <= 1'b1;
`ifdef SCAN_FRAME_CHKSUM_EN
                  chk_q   <= '0;
`endif
               end
            end
            HDR0: begin
               if (bus.i_tx_rdy) begin
                  state_q <= HDR1;
                  word_q  <= {8'h01, 8'h00, LEN_WORD};
                  sop_q   <= 1'b0;
               end
            end
            HDR1: begin
               if (bus.i_tx_rdy) begin
                  state_q <= PAYLOAD;
                  word_q  <= '0;
                  vld_q   <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            PAYLOAD: begin
               if (pay_hs) begin
                  cnt_q <= cnt_q + 16'd1;
`ifdef SCAN_FRAME_CHKSUM_EN
                  chk_q <= chk_q + bus.i_st_data;
                  if (last_pay) begin
                     state_q <= TRAIL;
                     word_q  <= chk_q + bus.i_st_data;
                     vld_q   <= 1'b1;
                     eop_q   <= 1'b1;
                  end
`else
                  if (last_pay) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
`endif
               end
            end
`ifdef SCAN_FRAME_CHKSUM_EN
            TRAIL: begin
               if (bus.i_tx_rdy) begin
                  state_q <= IDLE;
                  word_q  <= '0;
                  vld_q   <= 1'b0;
                  eop_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
`endif
            default: begin
               state_q <= IDLE;
               word_q  <= '0;
               vld_q   <= 1'b0;
               sop_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_frame_pack.sv
// Self-checking bench for scan_frame_pack with SCAN_WORDS=4; expectations follow SCAN_FRAME_CHKSUM_EN.
module tb_scan_frame_pack;

   localparam int SW = 4;
`ifdef SCAN_FRAME_CHKSUM_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam int NW = 2 + SW + (CHK ? 1 : 0);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scan_frame_pack_if bus();

   scan_frame_pack #(.SCAN_WORDS(SW), .SYNC_WORD(16'hA55A)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_frames;
   logic [7:0]  exp_drops;
   logic [31:0] pl [SW];

   typedef struct {
      logic        sync;
      logic [31:0] st_data;
      logic        st_vld;
      logic        tx_rdy;
      logic        e_vld;
      logic [31:0] e_data;
      logic        e_sop;
      logic        e_eop;
      logic        e_rdy;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic s, input logic [31:0] d, input logic v, input logic r,
                               input logic ev, input logic [31:0] ed, input logic es,
                               input logic ee, input logic er, input logic eb);
      vec_t x;
      x.sync = s;  x.st_data = d; x.st_vld = v; x.tx_rdy = r;
      x.e_vld = ev; x.e_data = ed; x.e_sop = es; x.e_eop = ee; x.e_rdy = er; x.e_busy = eb;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic s, input logic [31:0] d, input logic v, input logic r);
      bus.i_send_sync = s;
      bus.i_st_data   = d;
      bus.i_st_vld    = v;
      bus.i_tx_rdy    = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete frame from the sync cycle to the EOP handshake.
   // bp: toggle tx_rdy and gap st_vld; n_sync: syncs to inject while busy; stall: leading rdy-low cycles.
   task automatic run_frame(input int bp, input int n_sync, input int stall);
      logic [31:0] exp_w [NW];
      logic [31:0] sum, held_d, d;
      logic        held, in_pay, r, v, s, hs;
      int          k, cyc, left;
      sum = '0;
      exp_w[0] = {16'hA55A, exp_frames};
      exp_w[1] = 32'h0100_0004;
      for (int i = 0; i < SW; i++) begin
         exp_w[2+i] = pl[i];
         sum        = sum + pl[i];
      end
      if (CHK) exp_w[NW-1] = sum;

      drive(1'b1, '0, 1'b0, 1'b1);
      #1;
      check("start_busy_low", {31'd0, bus.o_busy}, 32'd0);
      check("start_vld_low", {31'd0, bus.o_tx_vld}, 32'd0);
      tick();

      k = 0; cyc = 0; left = n_sync; held = 1'b0; held_d = '0;
      while (k < NW && cyc < stall + 200) begin
         in_pay = (k >= 2) && (k < 2 + SW);
         r = (cyc < stall) ? 1'b0 : ((bp != 0) ? ((cyc % 2) == 1) : 1'b1);
         if (in_pay) v = (bp != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
         else        v = 1'($urandom_range(0, 1));
         d = in_pay ? pl[k-2] : $urandom;
         s = (left > 0);
         if (s) begin
            left--;
            if (exp_drops != 8'hFF) exp_drops++;
         end
         drive(s, d, v, r);
         #1;
         check("st_rdy", {31'd0, bus.o_st_rdy}, {31'd0, in_pay & r});
         check("tx_vld", {31'd0, bus.o_tx_vld}, {31'd0, in_pay ? v : 1'b1});
         if (held) check("hdr_hold", bus.o_tx_data, held_d);
         hs = in_pay ? (v & r) : r;
         if (hs) begin
            check("word", bus.o_tx_data, exp_w[k]);
            check("sop", {31'd0, bus.o_tx_sop}, {31'd0, k == 0});
            check("eop", {31'd0, bus.o_tx_eop}, {31'd0, k == NW - 1});
            k++;
            held = 1'b0;
            if (k == NW) exp_frames++;
         end else begin
            held   = !in_pay;
            held_d = bus.o_tx_data;
         end
         tick();
         cyc++;
      end
      check("frame_words", k, NW);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("after_busy", {31'd0, bus.o_busy}, 32'd0);
      check("after_vld", {31'd0, bus.o_tx_vld}, 32'd0);
      check("frame_cnt", {16'd0, bus.o_frame_cnt}, {16'd0, exp_frames});
      check("drop_cnt", {24'd0, bus.o_drop_cnt}, {24'd0, exp_drops});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vld"},   {31'd0, bus.o_tx_vld},  32'd0);
      check({tag, "_sop"},   {31'd0, bus.o_tx_sop},  32'd0);
      check({tag, "_eop"},   {31'd0, bus.o_tx_eop},  32'd0);
      check({tag, "_rdy"},   {31'd0, bus.o_st_rdy},  32'd0);
      check({tag, "_busy"},  {31'd0, bus.o_busy},    32'd0);
      check({tag, "_data"},  bus.o_tx_data,          32'd0);
      check({tag, "_frame"}, {16'd0, bus.o_frame_cnt}, 32'd0);
      check({tag, "_drop"},  {24'd0, bus.o_drop_cnt},  32'd0);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      exp_frames = '0;
      exp_drops  = '0;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // Basic frame: sync, headers, payload 1..4, optional trailer 0xA, then idle.
      vecs.push_back(mk(1, 0, 0, 1,  0, 32'h0,         0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1,  1, 32'hA55A_0000, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1,  1, 32'h0100_0004, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 1,  1, 32'h1,         0, 0, 1, 1));
      vecs.push_back(mk(0, 2, 1, 1,  1, 32'h2,         0, 0, 1, 1));
      vecs.push_back(mk(0, 3, 1, 1,  1, 32'h3,         0, 0, 1, 1));
      vecs.push_back(mk(0, 4, 1, 1,  1, 32'h4,         0, !CHK, 1, 1));
      vecs.push_back(CHK ? mk(0, 0, 0, 1,  1, 32'hA, 0, 1, 0, 1)
                         : mk(0, 0, 0, 1,  0, 32'h0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1,  0, 32'h0,         0, 0, 0, 0));
      foreach (vecs[i]) begin
         drive(vecs[i].sync, vecs[i].st_data, vecs[i].st_vld, vecs[i].tx_rdy);
         #1;
         check($sformatf("v%0d_vld", i),  {31'd0, bus.o_tx_vld}, {31'd0, vecs[i].e_vld});
         check($sformatf("v%0d_data", i), bus.o_tx_data,         vecs[i].e_data);
         check($sformatf("v%0d_sop", i),  {31'd0, bus.o_tx_sop}, {31'd0, vecs[i].e_sop});
         check($sformatf("v%0d_eop", i),  {31'd0, bus.o_tx_eop}, {31'd0, vecs[i].e_eop});
         check($sformatf("v%0d_rdy", i),  {31'd0, bus.o_st_rdy}, {31'd0, vecs[i].e_rdy});
         check($sformatf("v%0d_busy", i), {31'd0, bus.o_busy},   {31'd0, vecs[i].e_busy});
         tick();
      end
      exp_frames = 16'd1;
      check("basic_frame_cnt", {16'd0, bus.o_frame_cnt}, 32'd1);
      check("basic_drop_cnt",  {24'd0, bus.o_drop_cnt},  32'd0);

      // Back-pressure with the same payload.
      for (int i = 0; i < SW; i++) pl[i] = 32'(i + 1);
      run_frame(1, 0, 0);

      // Checksum wrap: 4 x FFFFFFFF sums to FFFFFFFC.
      for (int i = 0; i < SW; i++) pl[i] = 32'hFFFF_FFFF;
      run_frame(0, 0, 0);

      // Three syncs while busy are dropped, frame unaffected.
      for (int i = 0; i < SW; i++) pl[i] = 32'h1000 + 32'(i);
      run_frame(0, 3, 0);
      check("drop_three", {24'd0, bus.o_drop_cnt}, 32'd3);

      // Back-to-back frames: sync in the cycle after EOP starts the next one.
      run_frame(0, 0, 0);
      run_frame(1, 0, 0);

      // Sync on every busy cycle, including the final handshake: returns to IDLE.
      run_frame(0, 1000, 0);
      tick();
      check("spam_idle_busy", {31'd0, bus.o_busy}, 32'd0);

      // 300 syncs while stalled in HDR0 saturate the drop counter.
      run_frame(0, 300, 300);
      check("drop_saturate", {24'd0, bus.o_drop_cnt}, 32'd255);

      // Reset during payload word 2.
      for (int i = 0; i < SW; i++) pl[i] = 32'(i + 1);
      drive(1'b1, '0, 1'b0, 1'b1);  tick();
      drive(1'b0, '0, 1'b0, 1'b1);  tick();
      tick();
      drive(1'b0, 32'd1, 1'b1, 1'b1); tick();
      drive(1'b0, 32'd2, 1'b1, 1'b1); tick();
      drive(1'b0, 32'd3, 1'b1, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
      #1;
      check_all_zero("midrst");
      exp_frames = '0;
      exp_drops  = '0;
      tick();
      run_frame(0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
